// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: fetch port A, load/store port B and RAM-side signals of the RAM access controller
interface ram_access_ctrl_if #(
    parameter int dataW = 32,
    parameter int RAMAddrSize = 8
);
    logic                   AReq;
    logic [RAMAddrSize-1:0] AAddr;
    logic [dataW-1:0]       ARdata;
    logic                   AAck;
    logic                   BReq;
    logic                   BWe;
    logic [dataW/8-1:0]     BMask;
    logic [RAMAddrSize-1:0] BAddr;
    logic [dataW-1:0]       BWdata;
    logic [dataW-1:0]       BRdata;
    logic                   BAck;
    logic [RAMAddrSize-1:0] RAMAddr;
    logic [dataW-1:0]       DataIn;
    logic                   WriteControl;
    logic [dataW-1:0]       RAMOut;

    modport slave (
        input  AReq, AAddr, BReq, BWe, BMask, BAddr, BWdata, RAMOut,
        output ARdata, AAck, BRdata, BAck, RAMAddr, DataIn, WriteControl
    );

    modport master (
        output AReq, AAddr, BReq, BWe, BMask, BAddr, BWdata, RAMOut,
        input  ARdata, AAck, BRdata, BAck, RAMAddr, DataIn, WriteControl
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: shares a zero-delay single-port RAM between fetch (A) and load/store (B); define RAMCTRL_FIXED_PRIO_EN to make B always win contention
module ram_access_ctrl #(
    parameter int dataW = 32,
    parameter int RAMAddrSize = 8
) (
    input logic              clock,
    input logic              reset,
    ram_access_ctrl_if.slave bus
);
    localparam int NB = dataW / 8;

    typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

    state_t                 state;
    logic [RAMAddrSize-1:0] m_addr;
    logic [dataW-1:0]       m_data;
    logic [dataW-1:0]       merged;
    logic                   gnt_b;
    logic                   any_req;
    logic                   is_read;
    logic                   full;
    logic                   partial;

`ifdef RAMCTRL_FIXED_PRIO_EN
    assign gnt_b = bus.BReq;
`else
    logic prio;
    assign gnt_b = bus.BReq && (!bus.AReq || prio);
`endif

    assign any_req = bus.AReq || bus.BReq;
    assign is_read = !gnt_b || !bus.BWe;
    assign full    = !is_read && (&bus.BMask);
    assign partial = !is_read && (|bus.BMask) && !(&bus.BMask);

    // byte merge of store data over the current RAM word, captured at the end of the grant cycle
    always_comb begin
        merged = '0;
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = bus.BMask[i] ? bus.BWdata[8*i +: 8] : bus.RAMOut[8*i +: 8];
    end

    // RAM drive: granted address during the grant cycle, latched merge write in MERGE, zero otherwise
    always_comb begin
        bus.RAMAddr      = '0;
        bus.DataIn       = '0;
        bus.WriteControl = 1'b0;
        if (state == MERGE) begin
            bus.RAMAddr      = m_addr;
            bus.DataIn       = m_data;
            bus.WriteControl = 1'b1;
        end else if (state == IDLE && any_req) begin
            bus.RAMAddr      = gnt_b ? bus.BAddr : bus.AAddr;
            bus.DataIn       = full ? bus.BWdata : '0;
            bus.WriteControl = full;
        end
    end

    // access sequencer: grant, optional merge write, one-cycle acknowledge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            m_addr     <= '0;
            m_data     <= '0;
            bus.ARdata <= '0;
            bus.BRdata <= '0;
            bus.AAck   <= 1'b0;
            bus.BAck   <= 1'b0;
`ifndef RAMCTRL_FIXED_PRIO_EN
            prio       <= 1'b0;
`endif
        end else begin
            bus.AAck <= 1'b0;
            bus.BAck <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
`ifndef RAMCTRL_FIXED_PRIO_EN
                    prio <= !gnt_b;
`endif
                    if (partial) begin
                        m_addr <= bus.BAddr;
                        m_data <= merged;
                        state  <= MERGE;
                    end else begin
                        state    <= RESP;
                        bus.AAck <= !gnt_b;
                        bus.BAck <= gnt_b;
                        if (!gnt_b)
                            bus.ARdata <= bus.RAMOut;
                        else if (!bus.BWe)
                            bus.BRdata <= bus.RAMOut;
                    end
                end
                MERGE: begin
                    state    <= RESP;
                    bus.BAck <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: randomized self-checking bench with a word-array memory model and access-level timing model
module tb_ram_access_ctrl;
    logic clock;
    logic reset;
    logic load_en;

    ram_access_ctrl_if #(.dataW(32), .RAMAddrSize(8)) bus ();

    ram_access_ctrl #(.dataW(32), .RAMAddrSize(8)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_ard;
    logic [31:0] exp_brd;
    bit          prio_m;
    int          wc_cnt;
    int          checks;
    int          errors;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.RAMOut = mem[bus.RAMAddr];

    always @(posedge clock) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= ref_mem[i];
        end else if (bus.WriteControl) begin
            mem[bus.RAMAddr] <= bus.DataIn;
        end
    end

    always @(posedge clock)
        if (bus.WriteControl) wc_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat(input bit port_b, input bit we, input logic [3:0] mask);
        return (port_b && we && mask != 4'h0 && mask != 4'hF) ? 2 : 1;
    endfunction

    function automatic int nwrites(input bit port_b, input bit we, input logic [3:0] mask);
        return (port_b && we && mask != 4'h0) ? 1 : 0;
    endfunction

    task automatic model_access(input bit port_b, input bit we, input logic [3:0] mask,
                                input logic [7:0] addr, input logic [31:0] wd);
        if (!port_b) begin
            exp_ard = ref_mem[addr];
        end else if (!we) begin
            exp_brd = ref_mem[addr];
        end else begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
        end
        prio_m = !port_b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_aack"}, bus.AAck, 0);
        check({tag, "_back"}, bus.BAck, 0);
        check({tag, "_addr"}, bus.RAMAddr, 0);
        check({tag, "_din"}, bus.DataIn, 0);
        check({tag, "_wc"}, bus.WriteControl, 0);
    endtask

    task automatic single(input bit port_b, input bit we, input logic [3:0] mask,
                          input logic [7:0] addr, input logic [31:0] wd);
        int n;
        int wc0;
        wc0 = wc_cnt;
        if (port_b) begin
            bus.BReq = 1'b1; bus.BWe = we; bus.BMask = mask; bus.BAddr = addr; bus.BWdata = wd;
        end else begin
            bus.AReq = 1'b1; bus.AAddr = addr;
        end
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!(port_b ? bus.BAck : bus.AAck) && n < 8);
        model_access(port_b, we, mask, addr, wd);
        check(port_b ? "b_latency" : "a_latency", n, lat(port_b, we, mask));
        check("other_ack", port_b ? bus.AAck : bus.BAck, 0);
        check("ardata", bus.ARdata, exp_ard);
        check("brdata", bus.BRdata, exp_brd);
        check("writes", wc_cnt - wc0, nwrites(port_b, we, mask));
        check("resp_wc", bus.WriteControl, 0);
        check("mem_word", mem[addr], ref_mem[addr]);
        bus.AReq = 1'b0;
        bus.BReq = 1'b0;
        @(posedge clock); #1;
        check_idle_outputs("after");
    endtask

    task automatic contend(input bit we, input logic [3:0] mask, input logic [7:0] addr_a,
                           input logic [7:0] addr_b, input logic [31:0] wd);
        int ta;
        int tb;
        int n;
        int lf;
        int ls;
        bit first_b;
`ifdef RAMCTRL_FIXED_PRIO_EN
        first_b = 1'b1;
`else
        first_b = prio_m;
`endif
        bus.AReq = 1'b1; bus.AAddr = addr_a;
        bus.BReq = 1'b1; bus.BWe = we; bus.BMask = mask; bus.BAddr = addr_b; bus.BWdata = wd;
        ta = -1;
        tb = -1;
        n = 0;
        while ((ta < 0 || tb < 0) && n < 20) begin
            @(posedge clock); #1; n++;
            if (bus.AAck && ta < 0) begin ta = n; bus.AReq = 1'b0; end
            if (bus.BAck && tb < 0) begin tb = n; bus.BReq = 1'b0; end
        end
        bus.AReq = 1'b0;
        bus.BReq = 1'b0;
        lf = first_b ? lat(1, we, mask) : 1;
        ls = first_b ? 1 : lat(1, we, mask);
        if (first_b) begin
            model_access(1, we, mask, addr_b, wd);
            model_access(0, 0, 4'h0, addr_a, 32'h0);
        end else begin
            model_access(0, 0, 4'h0, addr_a, 32'h0);
            model_access(1, we, mask, addr_b, wd);
        end
        check("cont_first", first_b ? tb : ta, lf);
        check("cont_second", first_b ? ta : tb, lf + 1 + ls);
        check("cont_ardata", bus.ARdata, exp_ard);
        check("cont_brdata", bus.BRdata, exp_brd);
        check("cont_mem_a", mem[addr_a], ref_mem[addr_a]);
        check("cont_mem_b", mem[addr_b], ref_mem[addr_b]);
        @(posedge clock); #1;
        check_idle_outputs("cont_after");
    endtask

    task automatic reset_mid_rmw(input logic [7:0] addr, input logic [31:0] wd);
        bus.BReq = 1'b1; bus.BWe = 1'b1; bus.BMask = 4'b0011; bus.BAddr = addr; bus.BWdata = wd;
        @(posedge clock); #1;
        check("rmw_merge_wc", bus.WriteControl, 1);
        reset = 1'b1;
        #1;
        check("rst_wc_now", bus.WriteControl, 0);
        check("rst_back_now", bus.BAck, 0);
        @(posedge clock); #1;
        check("rst_mem", mem[addr], ref_mem[addr]);
        check("rst_back", bus.BAck, 0);
        bus.BReq = 1'b0;
        reset = 1'b0;
        exp_ard = '0;
        exp_brd = '0;
        prio_m = 1'b0;
        @(posedge clock); #1;
        check_idle_outputs("post_rst");
        check("post_rst_ard", bus.ARdata, exp_ard);
        check("post_rst_brd", bus.BRdata, exp_brd);
        check("post_rst_mem", mem[addr], ref_mem[addr]);
    endtask

    initial begin
        bit          pb;
        bit          we;
        logic [3:0]  mask;
        logic [7:0]  aa;
        logic [7:0]  ab;
        int          r;
        checks = 0;
        errors = 0;
        wc_cnt = 0;
        exp_ard = '0;
        exp_brd = '0;
        prio_m = 1'b0;
        reset = 1'b1;
        load_en = 1'b1;
        bus.AReq = 1'b0; bus.AAddr = '0;
        bus.BReq = 1'b0; bus.BWe = 1'b0; bus.BMask = '0; bus.BAddr = '0; bus.BWdata = '0;
        for (int i = 0; i < 256; i++)
            ref_mem[i] = $urandom;
        ref_mem[64] = 32'd90;
        ref_mem[8]  = 32'h11223344;
        @(posedge clock); #1;
        load_en = 1'b0;
        check_idle_outputs("reset");
        check("reset_ard", bus.ARdata, 0);
        check("reset_brd", bus.BRdata, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_idle_outputs("released");

        single(0, 0, 4'h0, 8'd64, 32'h0);
        check("fetch_64", bus.ARdata, 32'd90);
        single(1, 1, 4'hF, 8'd68, 32'd91);
        single(1, 0, 4'h0, 8'd68, 32'h0);
        check("load_68", bus.BRdata, 32'd91);
        single(1, 1, 4'b0101, 8'd8, 32'hAABBCCDD);
        single(1, 0, 4'h0, 8'd8, 32'h0);
        check("load_8", bus.BRdata, 32'h11BB33DD);
        contend(0, 4'h0, 8'd64, 8'd68, 32'h0);
        single(0, 0, 4'h0, 8'd8, 32'h0);
        contend(0, 4'h0, 8'd68, 8'd64, 32'h0);
        contend(1, 4'b1010, 8'd8, 8'd8, 32'h55667788);
        single(1, 1, 4'h0, 8'd64, 32'hDEADBEEF);
        check("empty_store_64", mem[64], 32'd90);
        reset_mid_rmw(8'd20, 32'hCAFEF00D);

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 3);
            we = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: mask = 4'h0;
                1: mask = 4'hF;
                default: mask = 4'($urandom);
            endcase
            aa = 8'($urandom_range(0, 31));
            ab = 8'($urandom_range(0, 31));
            if (r == 0) begin
                contend(we, mask, aa, ab, $urandom);
            end else begin
                pb = $urandom_range(0, 1);
                single(pb, pb && we, mask, pb ? ab : aa, $urandom);
            end
        end

        for (int i = 0; i < 32; i++)
            check("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Access controller that shares the single-port zero-delay data RAM between the core's instruction-fetch port (A, read-only) and load/store port (B, read/write with byte mask). It sits between the core and `zeroDelayRAM`, driving `RAMAddr`, `DataIn` and `WriteControl` and sampling `RAMOut`. It arbitrates round-robin and completes each access with a one-cycle acknowledge pulse. Sub-word stores are implemented as a two-cycle read-modify-write.

## Interface
- `dataW`, 32: data word width; must be a multiple of 8.
- `RAMAddrSize`, 8: RAM address width.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `AReq`  in  1  fetch request; held until `AAck`.
- `AAddr`  in  RAMAddrSize  fetch address.
- `ARdata`  out  dataW  fetch read data; valid while `AAck`=1.
- `AAck`  out  1  fetch completion pulse.
- `BReq`  in  1  load/store request; held until `BAck`.
- `BWe`  in  1  1 = store, 0 = load.
- `BMask`  in  dataW/8  store byte enables; bit i covers byte i.
- `BAddr`  in  RAMAddrSize  load/store address.
- `BWdata`  in  dataW  store data.
- `BRdata`  out  dataW  load read data; valid while `BAck`=1.
- `BAck`  out  1  load/store completion pulse.
- `RAMAddr`  out  RAMAddrSize  to RAM address.
- `DataIn`  out  dataW  to RAM write data.
- `WriteControl`  out  1  to RAM write enable; the RAM writes on the rising edge.
- `RAMOut`  in  dataW  from RAM; combinational read of `RAMAddr`.

## Operation
- **States:** IDLE, MERGE, RESP.
- **IDLE:**
  - If any `Req` is high, grant one requester this cycle. The grant cycle is G.
  - Drive `RAMAddr` with the granted address.
- **Arbitration:**
  - If only one port requests, that port wins.
  - If both request, the port named by the `prio` flop wins.
  - After each grant, `prio` points to the other port.
  - `prio` resets to A.
- **Read (A, or B with `BWe`=0):**
  - At the end of G, latch `RAMOut` into that port's `Rdata`.
  - Next state is RESP.
- **Full store (`BMask` all ones):**
  - `DataIn`=`BWdata` and `WriteControl`=1 during G.
  - Next state is RESP.
- **Empty store (`BMask`=0):**
  - No RAM write.
  - Next state is RESP.
- **Partial store:**
  - At the end of G, latch `RAMOut` into the merge register. Next state is MERGE.
- **MERGE:**
  - `RAMAddr`=`BAddr`, `WriteControl`=1.
  - Byte i of `DataIn` = `BMask[i]` ? `BWdata` byte i : merge byte i.
  - Next state is RESP.
- **RESP:**
  - The served port's `Ack`=1 for exactly this cycle.
  - No grant is made; the next state is IDLE.
  - The requester treats its request as retired. A new request is evaluated in the following IDLE cycle.
- **Idle outputs:** when no access is active, `RAMAddr`=0, `DataIn`=0, `WriteControl`=0.
- **Data hold:** `ARdata`/`BRdata` hold their last captured value until the next read on that port.
- A store never updates `BRdata`.

## Timing
- **Reset values:**
  - `AAck`=`BAck`=0, `ARdata`=`BRdata`=0.
  - `RAMAddr`=0, `DataIn`=0, `WriteControl`=0.
  - State is IDLE, `prio`=A.
- **Latency:**
  - Read, full store and empty store: `Ack` at G+1.
  - Partial store: `Ack` at G+2.
- **Throughput:** one access per 2 cycles (3 cycles for a partial store).
- **Simultaneous requests:**
  - The loser waits.
  - It is granted in the first IDLE cycle after the winner's RESP.
- **Request changes:** changes to `Req`/`Addr`/`Wdata`/`Mask` while in MERGE or RESP are ignored. Requesters are required to hold them stable until `Ack`.
- **Reset during MERGE:** reset forces `WriteControl`=0 immediately and no write occurs. The store is lost and no `Ack` is issued.
- **Reset during RESP:** `Ack` drops immediately.

## Configuration
- **`RAMCTRL_FIXED_PRIO_EN` defined:** port B always wins when both request. `prio` is not implemented. Fetch can starve under continuous B traffic.
- **`RAMCTRL_FIXED_PRIO_EN` undefined:** round-robin as described under Operation.

## Test plan
- **Single fetch.** Preload addr 64 = 90. Pulse `AReq`, `AAddr`=64 until `AAck`.
  - Required: `AAck` one cycle after the grant, `ARdata`=90, `WriteControl` never 1.
- **Full store then load.** B store with `BAddr`=68, `BWdata`=91, `BMask`=4'hF; then a B load of 68.
  - Required: `WriteControl`=1 for exactly one cycle.
  - Required: `BAck` at G+1 for each access; the load returns `BRdata`=91.
- **Partial store.** Addr 8 holds 32'h11223344. Store `BWdata`=32'hAABBCCDD, `BMask`=4'b0101.
  - Required: `BAck` at G+2.
  - Required: a subsequent load of addr 8 returns 32'h11BB33DD.
- **Contention.** `AReq` and `BReq` rise in the same cycle and are held.
  - Required: A is served first and B next; the two `Ack` pulses are 2 cycles apart.
  - Repeat after the next grant: the port served second last time is now served first.
  - With `RAMCTRL_FIXED_PRIO_EN` defined: B is served first.
- **Empty store.** Store with `BMask`=0 to addr 64.
  - Required: `BAck` at G+1, `WriteControl` stays 0, and addr 64 is unchanged.
- **Reset mid-RMW.** Assert `reset` during MERGE of a partial store.
  - Required: `WriteControl` goes 0 immediately, the RAM word is unchanged, and no `BAck` is issued.
  - Required: after reset releases, all outputs are 0.
